// File: rtl/hash_pkg.sv
// Shared types and constants for the hash accumulator: FSM state encoding,
// default IV/K/rotate amount and a width-generic rotate-left helper.
package hash_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAbsorb,
        StFinal,
        StHold
    } hash_st_e;

    localparam logic [15:0] DefIv  = 16'hE667;
    localparam logic [15:0] DefK   = 16'h9E37;
    localparam int unsigned DefRot = 5;

    // Rotates the low w bits of x left by r (1 <= r < w <= 64); upper bits return as zero.
    function automatic logic [63:0] rotl(input logic [63:0] x, input int unsigned w,
                                         input int unsigned r);
        logic [63:0] mask;
        logic [63:0] xm;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        xm   = x & mask;
        return ((xm << r) | (xm >> (w - r))) & mask;
    endfunction

endpackage

// File: rtl/hash_mix_round.sv
// One combinational mix round: next = rotl(state ^ p, ROT) + K, mod 2^STATE_W.
module hash_mix_round
    import hash_pkg::*;
#(
    parameter int unsigned         STATE_W = 16,
    parameter int unsigned         ROT     = DefRot,
    parameter logic [STATE_W-1:0]  K       = STATE_W'(DefK)
) (
    input  logic [STATE_W-1:0] state,
    input  logic [5:0]         p,
    output logic [STATE_W-1:0] next
);

    logic [STATE_W-1:0] mixed;

    always_comb begin
        mixed = state ^ STATE_W'(p);
        next  = STATE_W'(rotl(64'(mixed), STATE_W, ROT)) + K;
    end

endmodule

// File: rtl/hash_accum.sv
// Absorbs valid symbol pairs into a hash state, runs blank finalisation rounds and
// holds the digest on a valid/ready handshake. HASH_ACCUM_STALLCNT_EN adds stall_cnt.
module hash_accum
    import hash_pkg::*;
#(
    parameter int unsigned        NUM_PAIRS    = 4,
    parameter int unsigned        FINAL_ROUNDS = 2,
    parameter int unsigned        STATE_W      = 16,
    parameter int unsigned        ROT          = DefRot,
    parameter logic [STATE_W-1:0] IV           = STATE_W'(DefIv),
    parameter logic [STATE_W-1:0] K            = STATE_W'(DefK)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               valid_in,
    input  logic [2:0]         input0,
    input  logic [2:0]         input1,
    input  logic               digest_ready,
    output logic               busy,
    output logic [STATE_W-1:0] digest,
    output logic               digest_valid
`ifdef HASH_ACCUM_STALLCNT_EN
    ,
    output logic [7:0]         stall_cnt
`endif
);

    localparam int unsigned CntMax = (NUM_PAIRS > FINAL_ROUNDS) ? NUM_PAIRS : FINAL_ROUNDS;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] LastPair  = CntW'(NUM_PAIRS - 1);
    localparam logic [CntW-1:0] LastFinal = CntW'((FINAL_ROUNDS == 0) ? 0 : FINAL_ROUNDS - 1);

    hash_st_e           st_q, st_d;
    logic [STATE_W-1:0] hstate_q, hstate_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [STATE_W-1:0] digest_q, digest_d;
    logic               busy_q, busy_d;
    logic               digest_valid_q, digest_valid_d;
    logic [5:0]         mix_p;
    logic [STATE_W-1:0] mix_next;

    // Single mix instance: pair symbols while absorbing, zero during finalisation.
    assign mix_p = (st_q == StAbsorb) ? {input1, input0} : 6'd0;

    hash_mix_round #(
        .STATE_W (STATE_W),
        .ROT     (ROT),
        .K       (K)
    ) u_mix (
        .state (hstate_q),
        .p     (mix_p),
        .next  (mix_next)
    );

    always_comb begin
        st_d     = st_q;
        hstate_d = hstate_q;
        cnt_d    = cnt_q;
        digest_d = digest_q;
        unique case (st_q)
            StIdle: begin
                if (start) begin
                    hstate_d = IV;
                    cnt_d    = '0;
                    st_d     = StAbsorb;
                end
            end
            StAbsorb: begin
                if (valid_in) begin
                    hstate_d = mix_next;
                    if (cnt_q == LastPair) begin
                        cnt_d = '0;
                        if (FINAL_ROUNDS == 0) begin
                            st_d     = StHold;
                            digest_d = mix_next;
                        end else begin
                            st_d = StFinal;
                        end
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StFinal: begin
                hstate_d = mix_next;
                if (cnt_q == LastFinal) begin
                    cnt_d    = '0;
                    st_d     = StHold;
                    digest_d = mix_next;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StHold: begin
                if (digest_ready) begin
                    st_d = StIdle;
                end
            end
            default: st_d = StIdle;
        endcase
        busy_d         = (st_d != StIdle);
        digest_valid_d = (st_d == StHold);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q           <= StIdle;
            hstate_q       <= '0;
            cnt_q          <= '0;
            digest_q       <= '0;
            busy_q         <= 1'b0;
            digest_valid_q <= 1'b0;
        end else begin
            st_q           <= st_d;
            hstate_q       <= hstate_d;
            cnt_q          <= cnt_d;
            digest_q       <= digest_d;
            busy_q         <= busy_d;
            digest_valid_q <= digest_valid_d;
        end
    end

    assign busy         = busy_q;
    assign digest       = digest_q;
    assign digest_valid = digest_valid_q;

`ifdef HASH_ACCUM_STALLCNT_EN
    logic [7:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (st_q == StIdle && start) begin
            stall_cnt_d = '0;
        end else if (st_q == StAbsorb && !valid_in && stall_cnt_q != 8'hFF) begin
            stall_cnt_d = stall_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hash_accum.sv
// Directed, table-driven bench for hash_accum (default and NUM_PAIRS=1/FINAL_ROUNDS=0 builds).
module tb_hash_accum;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, valid_in, digest_ready;
    logic [2:0]  input0, input1;
    logic        busy, digest_valid;
    logic [15:0] digest;
    logic        start1, valid1, ready1;
    logic [2:0]  in0_1, in1_1;
    logic        busy1, dv1;
    logic [15:0] digest1;
`ifdef HASH_ACCUM_STALLCNT_EN
    logic [7:0]  stall_cnt, stall_cnt1;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hash_accum dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .valid_in     (valid_in),
        .input0       (input0),
        .input1       (input1),
        .digest_ready (digest_ready),
        .busy         (busy),
        .digest       (digest),
        .digest_valid (digest_valid)
`ifdef HASH_ACCUM_STALLCNT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    hash_accum #(
        .NUM_PAIRS    (1),
        .FINAL_ROUNDS (0)
    ) dut1 (
        .clk          (clk),
        .reset        (reset),
        .start        (start1),
        .valid_in     (valid1),
        .input0       (in0_1),
        .input1       (in1_1),
        .digest_ready (ready1),
        .busy         (busy1),
        .digest       (digest1),
        .digest_valid (dv1)
`ifdef HASH_ACCUM_STALLCNT_EN
        ,
        .stall_cnt    (stall_cnt1)
`endif
    );

    typedef struct {
        logic [11:0] in0s;   // pair i uses bits [3*i +: 3]
        logic [11:0] in1s;
        logic [3:0]  gaps;   // bit i: one invalid cycle before pair i
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mdl_mix(input logic [15:0] s, input logic [5:0] p);
        logic [15:0] x;
        x = s ^ {10'b0, p};
        return {x[10:0], x[15:11]} + 16'h9E37;
    endfunction

    function automatic logic [15:0] mdl_digest(input logic [11:0] in0s, input logic [11:0] in1s);
        logic [15:0] s;
        s = 16'hE667;
        for (int i = 0; i < 4; i++) s = mdl_mix(s, {in1s[3*i +: 3], in0s[3*i +: 3]});
        for (int i = 0; i < 2; i++) s = mdl_mix(s, 6'd0);
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one message on dut; returns edges from the start edge to digest_valid and the digest.
    task automatic run_msg(input vec_t v, output int lat, output logic [15:0] dig);
        start = 1'b1;
        tick();
        start = 1'b0;
        lat   = 0;
        for (int i = 0; i < 4; i++) begin
            if (v.gaps[i]) begin
                valid_in = 1'b0;
                tick();
                lat++;
            end
            valid_in = 1'b1;
            input0   = v.in0s[3*i +: 3];
            input1   = v.in1s[3*i +: 3];
            tick();
            lat++;
        end
        valid_in = 1'b0;
        while (!digest_valid && lat < 40) begin
            tick();
            lat++;
        end
        dig = digest;
    endtask

    task automatic ack();
        digest_ready = 1'b1;
        tick();
        digest_ready = 1'b0;
    endtask

    vec_t        vecs[5];
    int          lat;
    logic [15:0] dig, ref_dig, hold_dig;

    initial begin
        vecs[0] = '{in0s: 12'o1234, in1s: 12'o7654, gaps: 4'b0000, exp_lat: 6};
        vecs[1] = '{in0s: 12'o1234, in1s: 12'o7654, gaps: 4'b1111, exp_lat: 10};
        vecs[2] = '{in0s: 12'o0000, in1s: 12'o0000, gaps: 4'b0000, exp_lat: 6};
        vecs[3] = '{in0s: 12'o7777, in1s: 12'o7777, gaps: 4'b0111, exp_lat: 9};
        vecs[4] = '{in0s: 12'o5252, in1s: 12'o3030, gaps: 4'b1000, exp_lat: 7};

        reset = 1'b1; start = 1'b0; valid_in = 1'b0; digest_ready = 1'b0;
        input0 = '0; input1 = '0;
        start1 = 1'b0; valid1 = 1'b0; ready1 = 1'b0; in0_1 = '0; in1_1 = '0;
        tick();
        tick();
        reset = 1'b0;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_digest", 32'(digest), 32'd0);
        check("reset_dvalid", 32'(digest_valid), 32'd0);
`ifdef HASH_ACCUM_STALLCNT_EN
        check("reset_stall", 32'(stall_cnt), 32'd0);
`endif

        // Single-pair, no-finalisation build: rotl(E667^0009,5)+9E37 = 6C13.
        start1 = 1'b1;
        tick();
        start1 = 1'b0; valid1 = 1'b1; in0_1 = 3'd1; in1_1 = 3'd1;
        tick();
        valid1 = 1'b0;
        check("np1_dvalid", 32'(dv1), 32'd1);
        check("np1_digest", 32'(digest1), 32'h6C13);
        ready1 = 1'b1;
        tick();
        ready1 = 1'b0;
        check("np1_idle", 32'(dv1), 32'd0);

        foreach (vecs[k]) begin
            run_msg(vecs[k], lat, dig);
            check($sformatf("v%0d_latency", k), 32'(lat), 32'(vecs[k].exp_lat));
            check($sformatf("v%0d_digest", k), 32'(dig),
                  32'(mdl_digest(vecs[k].in0s, vecs[k].in1s)));
            check($sformatf("v%0d_busy_hold", k), 32'(busy), 32'd1);
`ifdef HASH_ACCUM_STALLCNT_EN
            check($sformatf("v%0d_stall", k), 32'(stall_cnt), 32'($countones(vecs[k].gaps)));
`endif
            if (k == 0) ref_dig = dig;
            if (k == 1) check("toggle_vs_b2b_digest", 32'(dig), 32'(ref_dig));
            ack();
            check($sformatf("v%0d_dvalid_fall", k), 32'(digest_valid), 32'd0);
            check($sformatf("v%0d_busy_idle", k), 32'(busy), 32'd0);
        end

        // HOLD with ready low for 5 cycles and a start pulse that must be ignored.
        run_msg(vecs[4], lat, hold_dig);
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            tick();
            check("hold_digest_stable", 32'(digest), 32'(hold_dig));
            check("hold_dvalid", 32'(digest_valid), 32'd1);
        end
        start = 1'b0;
        ack();
        check("hold_exit_busy", 32'(busy), 32'd0);
        check("hold_exit_dvalid", 32'(digest_valid), 32'd0);
        check("idle_digest_kept", 32'(digest), 32'(hold_dig));
        tick();
        check("start_in_hold_ignored", 32'(busy), 32'd0);

        // Reset after two absorbed pairs aborts the message.
        start = 1'b1;
        tick();
        start = 1'b0; valid_in = 1'b1; input0 = 3'd3; input1 = 3'd4;
        tick();
        tick();
        valid_in = 1'b0; reset = 1'b1; start = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_dvalid", 32'(digest_valid), 32'd0);
        check("abort_digest", 32'(digest), 32'd0);
        tick();
        tick();
        check("abort_stays_idle", 32'(busy), 32'd0);
        run_msg(vecs[3], lat, dig);
        check("after_abort_digest", 32'(dig), 32'(mdl_digest(vecs[3].in0s, vecs[3].in1s)));
        check("after_abort_latency", 32'(lat), 32'(vecs[3].exp_lat));
        ack();

`ifdef HASH_ACCUM_STALLCNT_EN
        // Stall counter saturation and clear on the next accepted start.
        start = 1'b1;
        tick();
        start = 1'b0; valid_in = 1'b0;
        for (int i = 0; i < 300; i++) tick();
        check("stall_saturate", 32'(stall_cnt), 32'd255);
        check("stall_busy", 32'(busy), 32'd1);
        valid_in = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        valid_in = 1'b0;
        lat = 0;
        while (!digest_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("stall_msg_done", 32'(digest_valid), 32'd1);
        check("stall_held_in_hold", 32'(stall_cnt), 32'd255);
        ack();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("stall_cleared", 32'(stall_cnt), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
